lc3_mem_arbiter: RTL and testbench

//  Shares the single-port 16-bit LC-3 main memory between two requesters:
//  the CPU datapath (MAR/MDR path) and a debug/loader port (program load,

---
 rtl/lc3_mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single-port LC-3 main memory between the CPU
// datapath and a debug/loader port. It arbitrates between them, sequences each
// access (issue, read-wait, return) and drives the RAM pins.
//
// Build option: define ARB_ROUND_ROBIN_EN to select strict alternation under
// contention. When it is undefined, the CPU has fixed priority and a
// starvation guard lets debug through after STARVE_LIMIT CPU grants.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   cpu_*_i / dbg_*_i         request, we, addr, wdata (held until gnt)
//   cpu_gnt_o / dbg_gnt_o     one-cycle pulse when the access hits memory
//   cpu_rvalid_o / dbg_rvalid_o  one-cycle pulse with read data
//   cpu_rdata_o / dbg_rdata_o last read data of that requester
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i   RAM pins
//   busy_o                    high whenever an access is in flight
module lc3_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;
    localparam int   CNT_W   = $clog2(RD_LAT + 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_wins;
    logic              any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`else
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
    logic [STV_W-1:0] starve_q, starve_d;
`endif

    assign any_req = cpu_req_i | dbg_req_i;

    // Winner selection; only meaningful while in IDLE with a request.
    always_comb begin
        dbg_wins = 1'b0;
        if (dbg_req_i && !cpu_req_i) begin
            dbg_wins = 1'b1;
        end else if (dbg_req_i && cpu_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            dbg_wins = (last_q == OWN_CPU);
`else
            dbg_wins = (starve_q == STV_MAX);
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = dbg_wins;
                    we_d    = dbg_wins ? dbg_we_i    : cpu_we_i;
                    addr_d  = dbg_wins ? dbg_addr_i  : cpu_addr_i;
                    wdata_d = dbg_wins ? dbg_wdata_i : cpu_wdata_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d  = CNT_W'(RD_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Last count step lines up with ISSUE + RD_LAT.
                if (wait_q == CNT_W'(1)) begin
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_rdata_d = mem_rdata_i;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_DBG;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && any_req) begin
            last_d = dbg_wins;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Counts CPU grants taken while debug waits; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!dbg_req_i) begin
            starve_d = '0;
        end else if (state_q == S_ISSUE) begin
            if (owner_q == OWN_DBG) begin
                starve_d = '0;
            end else if (starve_q != STV_MAX) begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end
`endif

    // Outputs
    always_comb begin
        mem_en_o     = (state_q == S_ISSUE);
        mem_we_o     = (state_q == S_ISSUE) && we_q;
        cpu_gnt_o    = (state_q == S_ISSUE) && (owner_q == OWN_CPU);
        dbg_gnt_o    = (state_q == S_ISSUE) && (owner_q == OWN_DBG);
        cpu_rvalid_o = (state_q == S_DONE) && (owner_q == OWN_CPU);
        dbg_rvalid_o = (state_q == S_DONE) && (owner_q == OWN_DBG);
        busy_o       = (state_q != S_IDLE);
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb_lc3_mem_arbiter: two arbiter instances (RD_LAT 1 and 3), each with its
// own RAM model; a negedge monitor checks grants and read returns.
module tb_lc3_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct packed {
        logic          own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
        logic [7:0]    lat;
    } rexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [2];
    logic          req    [2][2];
    logic          we     [2][2];
    logic [AW-1:0] addr   [2][2];
    logic [DW-1:0] wdata  [2][2];
    logic          gnt    [2][2];
    logic          rvalid [2][2];
    logic [DW-1:0] rdata  [2][2];
    logic          mem_en    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic          busy      [2];

    gexp_t gq [2][64];
    rexp_t rq [2][64];
    int gw [2];
    int gr [2];
    int rw [2];
    int rr [2];
    int gcyc [2];
    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem  [1024];
        logic [DW-1:0] pipe [RL];

        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= mem[mem_addr[g]];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        lc3_mem_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_LIMIT(4)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .cpu_req_i(req[g][0]), .cpu_we_i(we[g][0]),
            .cpu_addr_i(addr[g][0]), .cpu_wdata_i(wdata[g][0]),
            .cpu_gnt_o(gnt[g][0]), .cpu_rvalid_o(rvalid[g][0]),
            .cpu_rdata_o(rdata[g][0]),
            .dbg_req_i(req[g][1]), .dbg_we_i(we[g][1]),
            .dbg_addr_i(addr[g][1]), .dbg_wdata_i(wdata[g][1]),
            .dbg_gnt_o(gnt[g][1]), .dbg_rvalid_o(rvalid[g][1]),
            .dbg_rdata_o(rdata[g][1]),
            .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
            .mem_rdata_i(pipe[RL-1]), .busy_o(busy[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic mon_step(input int k);
        gexp_t e, a;
        rexp_t re, ra;
        if (gnt[k][0] || gnt[k][1]) begin
            a.own  = gnt[k][1];
            a.we   = mem_we[k];
            a.addr = mem_addr[k];
            a.wd   = mem_we[k] ? mem_wdata[k] : '0;
            nchk++;
            if (gr[k] == gw[k]) begin
                nerr++;
                $display("FAIL gnt%0d unexpected actual=%h required=none", k, a);
            end else begin
                e = gq[k][gr[k] % 64];
                gr[k]++;
                if (!e.we) e.wd = '0;
                if (a !== e || !mem_en[k] || (gnt[k][0] && gnt[k][1])) begin
                    nerr++;
                    $display("FAIL gnt%0d actual=%h en=%b both=%b required=%h",
                             k, a, mem_en[k], gnt[k][0] && gnt[k][1], e);
                end
            end
            gcyc[k] = cyc;
        end else if (mem_en[k]) begin
            nchk++;
            nerr++;
            $display("FAIL mem_en%0d actual=1 required=0 (no gnt)", k);
        end
        if (rvalid[k][0] || rvalid[k][1]) begin
            ra.own  = rvalid[k][1];
            ra.data = rdata[k][ra.own];
            ra.lat  = 8'(cyc - gcyc[k]);
            nchk++;
            if (rr[k] == rw[k]) begin
                nerr++;
                $display("FAIL rvalid%0d unexpected actual=%h required=none", k, ra);
            end else begin
                re = rq[k][rr[k] % 64];
                rr[k]++;
                if (ra !== re || (rvalid[k][0] && rvalid[k][1])) begin
                    nerr++;
                    $display("FAIL rvalid%0d actual=%h required=%h", k, ra, re);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (!rst[k]) mon_step(k);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int k, input logic own, output int n);
        bit hit = 0;
        n = 0;
        while (!hit && n < 50) begin
            @(negedge clk);
            n++;
            if (gnt[k][own]) hit = 1;
        end
        if (!hit) begin
            nchk++;
            nerr++;
            $display("FAIL gnt_timeout%0d actual=none required=gnt", k);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy[k]}, 32'd0);
        tick();
    endtask

    // Issues one access; returns cycles from req to gnt.
    task automatic issue(input int k, input logic own, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic rd_exp, input logic [DW-1:0] rexp,
                         output int n);
        gexp_t e;
        rexp_t r;
        e.own = own; e.we = w; e.addr = a; e.wd = d;
        gq[k][gw[k] % 64] = e;
        gw[k]++;
        if (!w && rd_exp) begin
            r.own  = own;
            r.data = rexp;
            r.lat  = 8'((k == 0) ? 2 : 4);
            rq[k][rw[k] % 64] = r;
            rw[k]++;
        end
        req[k][own] = 1'b1; we[k][own] = w;
        addr[k][own] = a; wdata[k][own] = d;
        wait_gnt(k, own, n);
        tick();
        req[k][own] = 1'b0;
    endtask

    int n;
    int ng;
    logic own_e;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            for (int o = 0; o < 2; o++) begin
                req[k][o] = 1'b0; we[k][o] = 1'b0;
                addr[k][o] = '0; wdata[k][o] = '0;
            end
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", {30'd0, gnt[k][0], gnt[k][1]}, 32'd0);
            chk("rst_rvalid", {30'd0, rvalid[k][0], rvalid[k][1]}, 32'd0);
            chk("rst_mem", {30'd0, mem_en[k], mem_we[k]}, 32'd0);
            chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            chk("rst_rdata", {rdata[k][0], rdata[k][1]}, 32'd0);
            chk("rst_maddr", {22'd0, mem_addr[k]}, 32'd0);
        end
        tick();

        // Loader write, then CPU read with RD_LAT=1.
        issue(0, 1'b1, 1'b1, 10'h005, 16'hBEEF, 1'b0, 16'h0, n);
        wait_idle(0);
        issue(0, 1'b0, 1'b0, 10'h005, 16'h0, 1'b1, 16'hBEEF, n);
        chk("req2gnt", n, 32'd2);
        wait_idle(0);
        chk("cpu_rdata", {16'd0, rdata[0][0]}, 32'h0000BEEF);

        // Debug write to top of memory; idle right after.
        issue(0, 1'b1, 1'b1, 10'h3FF, 16'h1234, 1'b0, 16'h0, n);
        @(negedge clk);
        chk("wr_busy", {31'd0, busy[0]}, 32'd0);
        chk("wr_rvalid", {31'd0, rvalid[0][1]}, 32'd0);
        tick();
        issue(0, 1'b1, 1'b0, 10'h3FF, 16'h0, 1'b1, 16'h1234, n);
        wait_idle(0);
        chk("dbg_rdata", {16'd0, rdata[0][1]}, 32'h00001234);
        chk("cpu_rdata_held", {16'd0, rdata[0][0]}, 32'h0000BEEF);

        // Continuous contention on both ports.
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            own_e = (i % 2 == 1);
`else
            own_e = (i % 5 == 4);
`endif
            gq[0][gw[0] % 64] = own_e ? {1'b1, 1'b1, 10'h020, 16'hD00D}
                                      : {1'b0, 1'b1, 10'h010, 16'hC0DE};
            gw[0]++;
        end
        req[0][0] = 1'b1; we[0][0] = 1'b1;
        addr[0][0] = 10'h010; wdata[0][0] = 16'hC0DE;
        req[0][1] = 1'b1; we[0][1] = 1'b1;
        addr[0][1] = 10'h020; wdata[0][1] = 16'hD00D;
        ng = 0;
        for (int t = 0; t < 60 && ng < 10; t++) begin
            @(negedge clk);
            if (gnt[0][0] || gnt[0][1]) ng++;
        end
        chk("contend_grants", ng, 32'd10);
        tick();
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        wait_idle(0);

        // RD_LAT=3: reset during WAIT drops the read.
        issue(1, 1'b1, 1'b1, 10'h040, 16'hA5A5, 1'b0, 16'h0, n);
        wait_idle(1);
        issue(1, 1'b0, 1'b0, 10'h040, 16'h0, 1'b0, 16'h0, n);
        chk("wait_busy", {31'd0, busy[1]}, 32'd1);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("rst_no_rvalid", {31'd0, rvalid[1][0]}, 32'd0);
        end
        chk("rst_busy1", {31'd0, busy[1]}, 32'd0);
        tick();
        issue(1, 1'b0, 1'b0, 10'h040, 16'h0, 1'b1, 16'hA5A5, n);
        wait_idle(1);
        chk("cpu_rdata1", {16'd0, rdata[1][0]}, 32'h0000A5A5);

        for (int t = 0; t < 6; t++) tick();
        for (int k = 0; k < 2; k++) begin
            chk("gq_drain", gr[k], gw[k]);
            chk("rq_drain", rr[k], rw[k]);
        end
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
